count_accumulator: RTL and testbench
====================================

# count_accumulator

Downstream consumer of the 4-bit `Count` produced by the counter FSM in the SimpleALU datapath. Samples `Count` every clock, detects each upstream increment, and folds the new count into a registered accumulator through a 2-bit selectable ALU operation. Flags wrap-around (15→0), upstream restarts (any non-increment change), and arithmetic overflow, so the ALU stage can be exercised by a free-running counter.

## Interface
- `ACC_W`, default 8: accumulator width in bits, minimum 4.
- `Clk`  in  1  rising-edge clock.
- `Rst`  in  1  asynchronous, active-low reset.
- `Count`  in  4  upstream counter value. Each value is held for at least one clock.
- `Enable`  in  1  level. 1 = process count changes, 0 = hold.
- `Clear`  in  1  synchronous accumulator clear.
- `Op`  in  2  operation: 00 ADD, 01 SUB, 10 AND, 11 XOR. Sampled on the step edge.
- `Acc`  out  ACC_W  accumulator value.
- `Step`  out  1  one-cycle pulse: an increment was accumulated.
- `Wrap`  out  1  one-cycle pulse: the accumulated increment was 15→0.
- `Restart`  out  1  one-cycle pulse: a non-increment change cleared `Acc`.
- `Ovf`  out  1  sticky overflow/borrow flag.
- `State`  out  2  00 IDLE, 01 ACCUM, 10 HOLD.

## Operation
- Internal `Count_q` register holds `Count` as sampled at the previous edge. It updates every cycle in every state.
- A change is defined as `Count != Count_q`. An increment is defined as `Count == Count_q + 1` mod 16.
- **IDLE**
  - All changes are ignored.
  - `Enable`=1 → ACCUM. No change is processed on the transition edge.
- **ACCUM**
  - Increment: `Acc <= Acc op zext(Count)`, `Step`=1. `Wrap`=1 additionally when `Count_q`=15 and `Count`=0.
  - Non-increment change (e.g. upstream reset): `Acc`<=0, `Ovf`<=0, `Restart`=1, no `Step`.
  - `Enable`=0 → HOLD. The change on that edge is not processed.
- **HOLD**
  - `Acc` and `Ovf` are frozen and changes are ignored.
  - `Enable`=1 → ACCUM. The change on that edge is not processed.
- `Clear`=1 in any state: `Acc`<=0, `Ovf`<=0, no pulses. `Clear` wins over a simultaneous change. The state is unaffected.
- Arithmetic:
  - `Count` is zero-extended to ACC_W bits.
  - ADD carry-out or SUB borrow sets `Ovf`. The result wraps mod 2^ACC_W.
  - AND and XOR never set `Ovf`.
  - `Ovf` clears only on `Clear`, `Restart`, or reset.

## Timing
- Reset (`Rst`=0, asynchronous): `Acc`=0, `Step`=`Wrap`=`Restart`=0, `Ovf`=0, `State`=IDLE, `Count_q`=0.
  - Outputs change without a clock.
  - Release is sampled at the next rising edge.
- Latency: a `Count` change sampled at edge k produces the new `Acc`, and exactly one of the pulses, during the cycle after edge k. There is no combinational path from `Count` to any output.
- Pulses last exactly one cycle. Back-to-back increments on consecutive edges give consecutive `Step` pulses.
- `Count` held constant: no pulses, `Acc` stable.
- Reset asserted mid-accumulation discards `Acc`. After release the block is in IDLE.

## Configuration
- `ACC_SATURATE_EN` defined:
  - ADD overflow clamps `Acc` to 2^ACC_W−1.
  - SUB borrow clamps `Acc` to 0.
  - `Ovf` is still set.
- Not defined: results wrap mod 2^ACC_W. All other behaviour is identical.

## Test plan
1. **Single pass.** ACC_W=8, Op=ADD, Enable=1, upstream counts 0→15. Expect `Acc`=120 after Count=15, 15 `Step` pulses, `Ovf`=0.
2. **Wrap and overflow.** Continue counting through 15→0. Expect:
   - a `Wrap` pulse with `Acc` unchanged at 120;
   - 240 after the second 15;
   - at Count=6 of the third pass, `Acc`=5 and `Ovf`=1;
   - with `ACC_SATURATE_EN`, `Acc`=255 instead.
3. **Upstream restart.** Count goes 0,1,2,3 then 0. Expect `Acc`=6 before the drop, then `Acc`=0 with a single `Restart` pulse, no `Step`, `Ovf`=0.
4. **SUB borrow.** Clear, then Op=SUB with Count 0→1. Expect `Acc`=255 and `Ovf`=1; with `ACC_SATURATE_EN`, `Acc`=0 and `Ovf`=1.
5. **Hold and clear.** Drop Enable at Count=4 (`Acc`=10) while counting continues to 9, then re-enable. Expect:
   - `Acc` stays 10 in HOLD;
   - the next increment 9→10 gives `Acc`=20;
   - `Clear` pulsed together with an increment gives `Acc`=0 and no `Step`.
6. **Async reset mid-run.** Drive `Rst`=0 between clock edges while `Acc`=45. Expect all outputs 0 and `State`=IDLE immediately. After release, no accumulation until `Enable` is seen at an edge.

Source files
------------

// File: rtl/count_accumulator_if.sv
// count_accumulator_if
//   Groups the count_accumulator data/control and status signals.
//   ACC_W : accumulator width (must match the attached count_accumulator).
//   master : upstream/driver side (drives Count, Enable, Clear, Op;
//            observes Acc, Step, Wrap, Restart, Ovf, State).
//   slave  : count_accumulator side (the opposite directions).
interface count_accumulator_if #(
    parameter int ACC_W = 8
);
    logic [3:0]       Count;
    logic             Enable;
    logic             Clear;
    logic [1:0]       Op;
    logic [ACC_W-1:0] Acc;
    logic             Step;
    logic             Wrap;
    logic             Restart;
    logic             Ovf;
    logic [1:0]       State;

    modport master (
        output Count, Enable, Clear, Op,
        input  Acc, Step, Wrap, Restart, Ovf, State
    );

    modport slave (
        input  Count, Enable, Clear, Op,
        output Acc, Step, Wrap, Restart, Ovf, State
    );
endinterface

// File: rtl/count_accumulator.sv
// count_accumulator
//   Samples a 4-bit upstream counter every clock, folds each increment into a
//   registered accumulator through a selectable ALU op (ADD/SUB/AND/XOR) and
//   flags wrap-around (15->0), upstream restarts and arithmetic overflow.
//   All outputs are registered; nothing from Count reaches an output
//   combinationally.
//
//   Ports:
//     Clk  : rising-edge clock
//     Rst  : asynchronous active-low reset
//     bus  : count_accumulator_if.slave
//            in : Count[3:0], Enable, Clear, Op[1:0]
//            out: Acc[ACC_W-1:0], Step, Wrap, Restart, Ovf, State[1:0]
//
//   Build option: define ACC_SATURATE_EN to clamp ADD overflow to all-ones
//   and SUB borrow to zero instead of wrapping (Ovf is set either way).
module count_accumulator #(
    parameter int ACC_W = 8
) (
    input  logic                Clk,
    input  logic                Rst,
    count_accumulator_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        HOLD  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } op_t;

    state_t           state_q;
    logic [3:0]       count_q;
    logic [ACC_W-1:0] acc_q;
    logic             step_q;
    logic             wrap_q;
    logic             restart_q;
    logic             ovf_q;

    logic [3:0]       count_inc;
    logic             is_change;
    logic             is_inc;
    logic             is_wrap;
    logic [ACC_W-1:0] count_ext;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W:0]   diff_ext;
    logic [ACC_W-1:0] acc_next;
    logic             ovf_set;

    assign count_inc = count_q + 4'd1;
    assign is_change = (bus.Count != count_q);
    assign is_inc    = (bus.Count == count_inc);
    assign is_wrap   = (count_q == 4'd15) && (bus.Count == 4'd0);
    assign count_ext = ACC_W'(bus.Count);

    // One extra bit captures ADD carry-out / SUB borrow.
    assign sum_ext   = {1'b0, acc_q} + {1'b0, count_ext};
    assign diff_ext  = {1'b0, acc_q} - {1'b0, count_ext};

    always_comb begin
        acc_next = acc_q;
        ovf_set  = 1'b0;
        case (op_t'(bus.Op))
            OP_ADD: begin
                acc_next = sum_ext[ACC_W-1:0];
                ovf_set  = sum_ext[ACC_W];
`ifdef ACC_SATURATE_EN
                if (sum_ext[ACC_W]) acc_next = '1;
`endif
            end
            OP_SUB: begin
                acc_next = diff_ext[ACC_W-1:0];
                ovf_set  = diff_ext[ACC_W];
`ifdef ACC_SATURATE_EN
                if (diff_ext[ACC_W]) acc_next = '0;
`endif
            end
            OP_AND: acc_next = acc_q & count_ext;
            OP_XOR: acc_next = acc_q ^ count_ext;
            default: acc_next = acc_q;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            step_q    <= 1'b0;
            wrap_q    <= 1'b0;
            restart_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            count_q   <= bus.Count;
            step_q    <= 1'b0;
            wrap_q    <= 1'b0;
            restart_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (bus.Enable) state_q <= ACCUM;
                end
                ACCUM: begin
                    if (!bus.Enable) begin
                        state_q <= HOLD;
                    end else if (is_change) begin
                        if (is_inc) begin
                            acc_q  <= acc_next;
                            step_q <= 1'b1;
                            wrap_q <= is_wrap;
                            if (ovf_set) ovf_q <= 1'b1;
                        end else begin
                            acc_q     <= '0;
                            ovf_q     <= 1'b0;
                            restart_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.Enable) state_q <= ACCUM;
                end
                default: state_q <= IDLE;
            endcase

            // Clear overrides whatever the state logic decided above,
            // but leaves the state itself untouched.
            if (bus.Clear) begin
                acc_q     <= '0;
                ovf_q     <= 1'b0;
                step_q    <= 1'b0;
                wrap_q    <= 1'b0;
                restart_q <= 1'b0;
            end
        end
    end

    assign bus.Acc     = acc_q;
    assign bus.Step    = step_q;
    assign bus.Wrap    = wrap_q;
    assign bus.Restart = restart_q;
    assign bus.Ovf     = ovf_q;
    assign bus.State   = state_q;

endmodule

// File: tb/tb_count_accumulator.sv
// tb_count_accumulator
//   Directed bench for count_accumulator (ACC_W = 8). Inputs change 1 time
//   unit after a rising edge; outputs are checked at the same point.
module tb_count_accumulator;

    localparam int ACC_W = 8;

`ifdef ACC_SATURATE_EN
    localparam int EXP_OVF_ADD = 255;
    localparam int EXP_SUB_BORROW = 0;
`else
    localparam int EXP_OVF_ADD = 5;
    localparam int EXP_SUB_BORROW = 255;
`endif

    logic Clk = 1'b0;
    logic Rst;

    always #5 Clk = ~Clk;

    count_accumulator_if #(.ACC_W(ACC_W)) bus ();

    count_accumulator #(.ACC_W(ACC_W)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int exp_acc;
    int step_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst        = 1'b0;
        bus.Count  = 4'd0;
        bus.Enable = 1'b0;
        bus.Clear  = 1'b0;
        bus.Op     = 2'b00;
        #2;
        chk("rst_acc", 32'(bus.Acc), 0);
        chk("rst_step", 32'(bus.Step), 0);
        chk("rst_wrap", 32'(bus.Wrap), 0);
        chk("rst_restart", 32'(bus.Restart), 0);
        chk("rst_ovf", 32'(bus.Ovf), 0);
        chk("rst_state", 32'(bus.State), 0);

        tick();
        tick();
        Rst = 1'b1;
        tick();
        chk("idle_after_rel", 32'(bus.State), 0);

        // IDLE ignores changes
        bus.Count = 4'd3;
        tick();
        chk("idle_ignore_acc", 32'(bus.Acc), 0);
        chk("idle_ignore_restart", 32'(bus.Restart), 0);
        bus.Count = 4'd0;
        tick();

        // Enter ACCUM; nothing processed on the transition edge
        bus.Enable = 1'b1;
        tick();
        chk("enter_accum", 32'(bus.State), 1);
        chk("enter_no_step", 32'(bus.Step), 0);

        // 1. Single pass 0->15
        exp_acc  = 0;
        step_cnt = 0;
        for (int i = 1; i <= 15; i++) begin
            bus.Count = 4'(i);
            tick();
            exp_acc += i;
            chk("pass1_acc", 32'(bus.Acc), 32'(exp_acc));
            step_cnt += int'(bus.Step);
        end
        chk("pass1_total", 32'(bus.Acc), 120);
        chk("pass1_steps", 32'(step_cnt), 15);
        chk("pass1_ovf", 32'(bus.Ovf), 0);

        // Count held: no pulses
        tick();
        chk("hold_const_step", 32'(bus.Step), 0);
        chk("hold_const_acc", 32'(bus.Acc), 120);

        // 2. Wrap and overflow
        bus.Count = 4'd0;
        tick();
        chk("wrap1_pulse", 32'(bus.Wrap), 1);
        chk("wrap1_step", 32'(bus.Step), 1);
        chk("wrap1_acc", 32'(bus.Acc), 120);
        for (int i = 1; i <= 15; i++) begin
            bus.Count = 4'(i);
            tick();
            if (i == 1) chk("wrap_one_cycle", 32'(bus.Wrap), 0);
        end
        chk("pass2_acc", 32'(bus.Acc), 240);
        chk("pass2_ovf", 32'(bus.Ovf), 0);
        bus.Count = 4'd0;
        tick();
        chk("wrap2_pulse", 32'(bus.Wrap), 1);
        for (int i = 1; i <= 5; i++) begin
            bus.Count = 4'(i);
            tick();
        end
        chk("pass3_c5_acc", 32'(bus.Acc), 255);
        chk("pass3_c5_ovf", 32'(bus.Ovf), 0);
        bus.Count = 4'd6;
        tick();
        chk("pass3_c6_acc", 32'(bus.Acc), 32'(EXP_OVF_ADD));
        chk("pass3_c6_ovf", 32'(bus.Ovf), 1);
        tick();
        chk("ovf_sticky", 32'(bus.Ovf), 1);

        // 3. Upstream restart
        bus.Count = 4'd0;
        tick();
        chk("rs1_restart", 32'(bus.Restart), 1);
        chk("rs1_acc", 32'(bus.Acc), 0);
        chk("rs1_ovf", 32'(bus.Ovf), 0);
        for (int i = 1; i <= 3; i++) begin
            bus.Count = 4'(i);
            tick();
        end
        chk("rs2_before", 32'(bus.Acc), 6);
        bus.Count = 4'd0;
        tick();
        chk("rs2_restart", 32'(bus.Restart), 1);
        chk("rs2_no_step", 32'(bus.Step), 0);
        chk("rs2_acc", 32'(bus.Acc), 0);
        chk("rs2_ovf", 32'(bus.Ovf), 0);
        tick();
        chk("rs2_one_cycle", 32'(bus.Restart), 0);

        // 4. SUB borrow
        bus.Clear = 1'b1;
        tick();
        bus.Clear = 1'b0;
        chk("clr_acc", 32'(bus.Acc), 0);
        chk("clr_state", 32'(bus.State), 1);
        bus.Op    = 2'b01;
        bus.Count = 4'd1;
        tick();
        chk("sub_acc", 32'(bus.Acc), 32'(EXP_SUB_BORROW));
        chk("sub_ovf", 32'(bus.Ovf), 1);
        chk("sub_step", 32'(bus.Step), 1);

        // 5. Hold and clear
        bus.Op    = 2'b00;
        bus.Count = 4'd0;
        tick();
        chk("h_restart_acc", 32'(bus.Acc), 0);
        chk("h_restart_ovf", 32'(bus.Ovf), 0);
        for (int i = 1; i <= 4; i++) begin
            bus.Count = 4'(i);
            tick();
        end
        chk("h_pre_acc", 32'(bus.Acc), 10);
        bus.Enable = 1'b0;
        bus.Count  = 4'd5;
        tick();
        chk("h_state", 32'(bus.State), 2);
        chk("h_edge_acc", 32'(bus.Acc), 10);
        chk("h_edge_step", 32'(bus.Step), 0);
        for (int i = 6; i <= 9; i++) begin
            bus.Count = 4'(i);
            tick();
            chk("h_frozen", 32'(bus.Acc), 10);
            chk("h_no_pulse", 32'(bus.Step | bus.Restart), 0);
        end
        bus.Enable = 1'b1;
        tick();
        chk("h_reenter", 32'(bus.State), 1);
        chk("h_reenter_acc", 32'(bus.Acc), 10);
        bus.Count = 4'd10;
        tick();
        chk("h_9to10", 32'(bus.Acc), 20);
        chk("h_9to10_step", 32'(bus.Step), 1);
        bus.Clear = 1'b1;
        bus.Count = 4'd11;
        tick();
        bus.Clear = 1'b0;
        chk("clr_inc_acc", 32'(bus.Acc), 0);
        chk("clr_inc_step", 32'(bus.Step), 0);

        // 6. Async reset mid-run
        bus.Count = 4'd0;
        tick();
        for (int i = 1; i <= 9; i++) begin
            bus.Count = 4'(i);
            tick();
        end
        chk("ar_pre_acc", 32'(bus.Acc), 45);
        #2;
        Rst = 1'b0;
        #1;
        chk("ar_acc", 32'(bus.Acc), 0);
        chk("ar_state", 32'(bus.State), 0);
        chk("ar_step", 32'(bus.Step), 0);
        chk("ar_ovf", 32'(bus.Ovf), 0);
        bus.Enable = 1'b0;
        bus.Count  = 4'd10;
        @(negedge Clk);
        Rst = 1'b1;
        tick();
        tick();
        chk("ar_rel_state", 32'(bus.State), 0);
        bus.Count = 4'd11;
        tick();
        chk("ar_idle_acc", 32'(bus.Acc), 0);
        chk("ar_idle_step", 32'(bus.Step), 0);
        bus.Enable = 1'b1;
        tick();
        chk("ar_en_state", 32'(bus.State), 1);
        chk("ar_en_acc", 32'(bus.Acc), 0);
        bus.Count = 4'd12;
        tick();
        chk("ar_first_inc", 32'(bus.Acc), 12);
        chk("ar_first_step", 32'(bus.Step), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
